// File: rtl/text_console_writer_if.sv
// Character stream handshake between a text source and the console writer.
interface text_console_writer_if;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_char, output in_valid, input in_ready);
  modport slave  (input in_char, input in_valid, output in_ready);
endinterface

// File: rtl/text_console_writer.sv
// Cursor-tracking character writer for the VGA text buffer: prints characters,
// interprets LF/CR/BS/FF and blanks rows or the whole screen one cell per cycle.
module text_console_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                 write_clk,
  input  logic                 reset,
  text_console_writer_if.slave in_port,
  output logic [4:0]           write_row,
  output logic [6:0]           write_col,
  output logic [7:0]           write_char,
  output logic                 write_en,
  output logic [4:0]           cursor_row,
  output logic [6:0]           cursor_col
);

  typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCREEN} state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t     state;
  logic [4:0] next_row;

  always_comb begin
    next_row = (cursor_row == LAST_ROW) ? '0 : cursor_row + 5'd1;
  end

  always_ff @(posedge write_clk) begin
    if (reset) begin
      state            <= CLR_SCREEN;
      in_port.in_ready <= 1'b0;
      write_en         <= 1'b0;
      write_row        <= '0;
      write_col        <= '0;
      write_char       <= '0;
      cursor_row       <= '0;
      cursor_col       <= '0;
    end else begin
      case (state)
        IDLE: begin
          write_en <= 1'b0;
          if (in_port.in_valid && in_port.in_ready) begin
            case (in_port.in_char)
              8'h0A: begin
                cursor_col       <= '0;
                cursor_row       <= next_row;
                state            <= CLR_LINE;
                in_port.in_ready <= 1'b0;
                write_en         <= 1'b1;
                write_row        <= next_row;
                write_col        <= '0;
                write_char       <= BLANK;
              end
              8'h0D: cursor_col <= '0;
              8'h08: begin
                if (cursor_col != '0) begin
                  cursor_col       <= cursor_col - 7'd1;
                  state            <= PUT;
                  in_port.in_ready <= 1'b0;
                  write_en         <= 1'b1;
                  write_row        <= cursor_row;
                  write_col        <= cursor_col - 7'd1;
                  write_char       <= BLANK;
                end
              end
              8'h0C: begin
                cursor_row       <= '0;
                cursor_col       <= '0;
                state            <= CLR_SCREEN;
                in_port.in_ready <= 1'b0;
                write_en         <= 1'b1;
                write_row        <= '0;
                write_col        <= '0;
                write_char       <= BLANK;
              end
              default: begin
                if (in_port.in_char >= 8'h20 && in_port.in_char != 8'h7F) begin
                  state            <= PUT;
                  in_port.in_ready <= 1'b0;
                  write_en         <= 1'b1;
                  write_row        <= cursor_row;
                  write_col        <= cursor_col;
                  write_char       <= in_port.in_char;
                  if (cursor_col == LAST_COL) begin
                    cursor_col <= '0;
                    cursor_row <= next_row;
                  end else begin
                    cursor_col <= cursor_col + 7'd1;
                  end
                end
              end
            endcase
          end
        end

        PUT: begin
          // Only a printable at the last column ever writes there (BS targets
          // col-1), so that address alone marks a wrap needing the new row blanked.
          if (write_col == LAST_COL) begin
            state      <= CLR_LINE;
            write_row  <= cursor_row;
            write_col  <= '0;
            write_char <= BLANK;
          end else begin
            state            <= IDLE;
            write_en         <= 1'b0;
            in_port.in_ready <= 1'b1;
          end
        end

        CLR_LINE: begin
          if (write_col == LAST_COL) begin
            state            <= IDLE;
            write_en         <= 1'b0;
            in_port.in_ready <= 1'b1;
          end else begin
            write_col <= write_col + 7'd1;
          end
        end

        CLR_SCREEN: begin
          // After reset write_en is low, so the first cycle here seeds cell (0,0).
          if (!write_en) begin
            write_en   <= 1'b1;
            write_row  <= '0;
            write_col  <= '0;
            write_char <= BLANK;
          end else if (write_col == LAST_COL) begin
            if (write_row == LAST_ROW) begin
              state            <= IDLE;
              write_en         <= 1'b0;
              in_port.in_ready <= 1'b1;
            end else begin
              write_row <= write_row + 5'd1;
              write_col <= '0;
            end
          end else begin
            write_col <= write_col + 7'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: vector table plus multi-cycle sequences.
module tb_text_console_writer;

  logic       clk;
  logic       reset;
  logic [4:0] write_row;
  logic [6:0] write_col;
  logic [7:0] write_char;
  logic       write_en;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  text_console_writer_if bus ();

  text_console_writer #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .write_clk  (clk),
    .reset      (reset),
    .in_port    (bus),
    .write_row  (write_row),
    .write_col  (write_col),
    .write_char (write_char),
    .write_en   (write_en),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [7:0] ch;
    int we;
    int wrow;
    int wcol;
    int wchar;
    int crow;
    int ccol;
    int rdy;
    int extra;
    int lrow;
    int lcol;
  } vec_t;

  typedef struct {
    int n;
    int nonblank;
    int frow;
    int fcol;
    int lrow;
    int lcol;
  } drain_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count writes in following cycles until in_ready returns, within a budget.
  task automatic drain(input int budget, output drain_t r);
    bit done;
    r = '{0, 0, -1, -1, -1, -1};
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (write_en) begin
        if (r.n == 0) begin
          r.frow = int'(write_row);
          r.fcol = int'(write_col);
        end
        r.lrow = int'(write_row);
        r.lcol = int'(write_col);
        if (write_char != 8'h20) r.nonblank++;
        r.n++;
      end
      if (bus.in_ready) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic xfer(input logic [7:0] c);
    check("ready_before_send", int'(bus.in_ready), 1);
    bus.in_char  = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic xfer_settle(input logic [7:0] c);
    drain_t r;
    xfer(c);
    if (!bus.in_ready) drain(200, r);
  endtask

  initial begin
    drain_t r;

    vecs[0]  = '{8'h41, 1, 0, 0, 8'h41, 0, 1, 0, 0, 0, 0};
    vecs[1]  = '{8'h6A, 1, 0, 1, 8'h6A, 0, 2, 0, 0, 0, 0};
    vecs[2]  = '{8'h0D, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0};
    vecs[3]  = '{8'h08, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0};
    vecs[4]  = '{8'h01, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0};
    vecs[5]  = '{8'h7F, 0, 0, 0, 0,     0, 0, 1, 0, 0, 0};
    vecs[6]  = '{8'h0A, 1, 1, 0, 8'h20, 1, 0, 0, 79, 1, 79};
    vecs[7]  = '{8'h0A, 1, 2, 0, 8'h20, 2, 0, 0, 79, 2, 79};
    vecs[8]  = '{8'h0A, 1, 3, 0, 8'h20, 3, 0, 0, 79, 3, 79};
    vecs[9]  = '{8'h31, 1, 3, 0, 8'h31, 3, 1, 0, 0, 0, 0};
    vecs[10] = '{8'h32, 1, 3, 1, 8'h32, 3, 2, 0, 0, 0, 0};
    vecs[11] = '{8'h33, 1, 3, 2, 8'h33, 3, 3, 0, 0, 0, 0};
    vecs[12] = '{8'h34, 1, 3, 3, 8'h34, 3, 4, 0, 0, 0, 0};
    vecs[13] = '{8'h35, 1, 3, 4, 8'h35, 3, 5, 0, 0, 0, 0};
    vecs[14] = '{8'h08, 1, 3, 4, 8'h20, 3, 4, 0, 0, 0, 0};
    vecs[15] = '{8'hC8, 1, 3, 4, 8'hC8, 3, 5, 0, 0, 0, 0};
    vecs[16] = '{8'h1B, 0, 0, 0, 0,     3, 5, 1, 0, 0, 0};
    vecs[17] = '{8'h0C, 1, 0, 0, 8'h20, 0, 0, 0, 2399, 29, 79};

    bus.in_char  = 8'h00;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    check("rst_write_en", int'(write_en), 0);
    check("rst_write_row", int'(write_row), 0);
    check("rst_write_col", int'(write_col), 0);
    check("rst_write_char", int'(write_char), 0);
    check("rst_cursor_row", int'(cursor_row), 0);
    check("rst_cursor_col", int'(cursor_col), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);

    reset = 1'b0;
    drain(3000, r);
    check("boot_writes", r.n, 2400);
    check("boot_nonblank", r.nonblank, 0);
    check("boot_first_row", r.frow, 0);
    check("boot_first_col", r.fcol, 0);
    check("boot_last_row", r.lrow, 29);
    check("boot_last_col", r.lcol, 79);
    check("boot_ready", int'(bus.in_ready), 1);
    check("boot_we_low", int'(write_en), 0);
    check("boot_cursor_row", int'(cursor_row), 0);
    check("boot_cursor_col", int'(cursor_col), 0);

    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].ch);
      check($sformatf("v%0d_write_en", i), int'(write_en), vecs[i].we);
      if (vecs[i].we != 0) begin
        check($sformatf("v%0d_write_row", i), int'(write_row), vecs[i].wrow);
        check($sformatf("v%0d_write_col", i), int'(write_col), vecs[i].wcol);
        check($sformatf("v%0d_write_char", i), int'(write_char), vecs[i].wchar);
      end
      check($sformatf("v%0d_cursor_row", i), int'(cursor_row), vecs[i].crow);
      check($sformatf("v%0d_cursor_col", i), int'(cursor_col), vecs[i].ccol);
      check($sformatf("v%0d_in_ready", i), int'(bus.in_ready), vecs[i].rdy);
      if (vecs[i].rdy == 0) begin
        drain(3000, r);
        check($sformatf("v%0d_extra_writes", i), r.n, vecs[i].extra);
        if (vecs[i].extra > 0) begin
          check($sformatf("v%0d_extra_nonblank", i), r.nonblank, 0);
          check($sformatf("v%0d_last_row", i), r.lrow, vecs[i].lrow);
          check($sformatf("v%0d_last_col", i), r.lcol, vecs[i].lcol);
        end
      end
    end

    // Wrap at (14,79): the printable lands there, then row 15 is blanked.
    for (int i = 0; i < 14; i++) xfer_settle(8'h0A);
    for (int i = 0; i < 79; i++) xfer_settle(8'h62);
    check("pre_wrap_cursor_row", int'(cursor_row), 14);
    check("pre_wrap_cursor_col", int'(cursor_col), 79);
    xfer(8'h5A);
    check("wrap_write_en", int'(write_en), 1);
    check("wrap_write_row", int'(write_row), 14);
    check("wrap_write_col", int'(write_col), 79);
    check("wrap_write_char", int'(write_char), 8'h5A);
    check("wrap_cursor_row", int'(cursor_row), 15);
    check("wrap_cursor_col", int'(cursor_col), 0);
    drain(200, r);
    check("wrap_clear_writes", r.n, 80);
    check("wrap_clear_nonblank", r.nonblank, 0);
    check("wrap_clear_first_row", r.frow, 15);
    check("wrap_clear_first_col", r.fcol, 0);
    check("wrap_clear_last_row", r.lrow, 15);
    check("wrap_clear_last_col", r.lcol, 79);

    // LF from the bottom row wraps to row 0 and blanks it.
    for (int i = 0; i < 14; i++) xfer_settle(8'h0A);
    check("bottom_cursor_row", int'(cursor_row), 29);
    xfer(8'h0A);
    check("lf_wrap_write_row", int'(write_row), 0);
    check("lf_wrap_write_col", int'(write_col), 0);
    check("lf_wrap_cursor_row", int'(cursor_row), 0);
    check("lf_wrap_cursor_col", int'(cursor_col), 0);
    drain(200, r);
    check("lf_wrap_writes", r.n + 1, 80);
    check("lf_wrap_last_row", r.lrow, 0);
    check("lf_wrap_last_col", r.lcol, 79);

    // CR then 0x01 with in_valid held: accepted on consecutive edges, no writes.
    xfer_settle(8'h78);
    check("cr_pre_cursor_col", int'(cursor_col), 1);
    bus.in_char  = 8'h0D;
    bus.in_valid = 1'b1;
    tick();
    check("cr_in_ready", int'(bus.in_ready), 1);
    check("cr_write_en", int'(write_en), 0);
    check("cr_cursor_col", int'(cursor_col), 0);
    bus.in_char = 8'h01;
    tick();
    bus.in_valid = 1'b0;
    check("ctl_in_ready", int'(bus.in_ready), 1);
    check("ctl_write_en", int'(write_en), 0);
    check("ctl_cursor_row", int'(cursor_row), 0);
    check("ctl_cursor_col", int'(cursor_col), 0);

    // FF, then reset 100 cycles into the sweep: sweep restarts from (0,0).
    xfer_settle(8'h71);
    xfer(8'h0C);
    check("ff_write_en", int'(write_en), 1);
    for (int i = 0; i < 99; i++) tick();
    check("ff_mid_row", int'(write_row), 1);
    check("ff_mid_col", int'(write_col), 19);
    reset = 1'b1;
    tick();
    check("midrst_write_en", int'(write_en), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_write_row", int'(write_row), 0);
    reset = 1'b0;
    drain(3000, r);
    check("resweep_writes", r.n, 2400);
    check("resweep_nonblank", r.nonblank, 0);
    check("resweep_first_row", r.frow, 0);
    check("resweep_first_col", r.fcol, 0);
    check("resweep_last_row", r.lrow, 29);
    check("resweep_last_col", r.lcol, 79);
    check("resweep_cursor_row", int'(cursor_row), 0);
    check("resweep_cursor_col", int'(cursor_col), 0);
    check("resweep_ready", int'(bus.in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream front end for the VGA text character buffer: accepts one 8-bit character at a time over a valid/ready handshake, tracks a cursor, interprets a small set of control codes, and drives the buffer's write port (row, col, char, enable). It sits between any text source (UART receiver, CPU register) and the character buffer. The character buffer is the read side consumed by the VGA scan-out.

## Interface
Parameters:
- COLS, 80, characters per row (≤128)
- ROWS, 30, rows per screen (≤32)
- BLANK, 8'h20, fill character for clears and backspace

Ports:
- write_clk  in  1  system clock; the same clock as the buffer write port
- reset  in  1  synchronous, active-high reset
- in_char  in  8  incoming character
- in_valid  in  1  in_char is valid
- in_ready  out  1  writer can accept a character this cycle
- write_row  out  5  buffer write row
- write_col  out  7  buffer write column
- write_char  out  8  buffer write data
- write_en  out  1  buffer write strobe; the buffer stores on a write_clk edge where this is high
- cursor_row  out  5  current cursor row
- cursor_col  out  7  current cursor column

## Operation
- A transfer happens on a write_clk edge where in_valid and in_ready are both 1.
- in_ready is 1 only in IDLE.
- FSM states:
  - IDLE
  - PUT: single write cycle
  - CLR_LINE: sweep one row
  - CLR_SCREEN: sweep all rows
- Character handling on accept:
  - Printable (anything not listed below, including 8'h80–8'hFF): go to PUT. The write is at the cursor.
    - If cursor_col < COLS-1: cursor_col+1.
    - Else: cursor_col←0, cursor_row advances, then go to CLR_LINE for the new row.
  - 8'h0A LF: cursor_col←0 and cursor_row advances. Go to CLR_LINE on the new row. No character is written.
  - 8'h0D CR: cursor_col←0. Stay in IDLE.
  - 8'h08 BS: if cursor_col>0, cursor_col−1 and go to PUT, writing BLANK at the new position. At col 0: no effect.
  - 8'h0C FF: go to CLR_SCREEN. Cursor ← (0,0).
  - All other codes < 8'h20, and 8'h7F: consumed, no effect.
- Row advance wraps: row ROWS-1 → 0. There is no scrolling; the row being entered is blanked instead.
- CLR_LINE: writes BLANK to cols 0..COLS-1 of cursor_row, one per cycle. Returns to IDLE after col COLS-1.
- CLR_SCREEN: writes BLANK row-major from (0,0) to (ROWS-1,COLS-1), one per cycle. Returns to IDLE after the last cell.
- in_char is not sampled while in_ready=0. A source holding in_valid keeps its character until accepted.

## Timing
- Reset values:
  - write_en=0, write_row=0, write_col=0, write_char=0
  - cursor_row=0, cursor_col=0
  - in_ready=0
- Reset enters CLR_SCREEN. in_ready rises after ROWS*COLS write cycles (2400 at defaults).
- Reset asserted mid-sweep or mid-PUT restarts CLR_SCREEN from cell (0,0). The cursor is zeroed.
- All outputs are registered. write_en is high exactly in the cycles after the FSM enters PUT, CLR_LINE or CLR_SCREEN, one cell per cycle.
- Printable or BS: accept at edge N; write_en=1 with the address and data during cycle N+1; in_ready=1 again in cycle N+2. Throughput is 1 char per 2 cycles.
- Wrapping printable: the PUT cycle is followed by COLS CLR_LINE cycles, then IDLE.
- LF: COLS write cycles, then in_ready.
- CR and ignored codes: in_ready stays 1; back-to-back accepts are allowed.
- FF: ROWS*COLS write cycles, then in_ready.
- cursor_row/cursor_col update on the accept edge. They show the post-command position during any write sequence.
- Column/row counters are compared against COLS-1/ROWS-1, never against the counter width.

## Test plan
- Reset, then count write_en cycles: exactly 2400 writes, all char 8'h20, last at (29,79). in_ready then 1, cursor (0,0).
- Send 'A' (65) then 'j' (106):
  - 'A' writes (0,0)=65; 'j' writes (0,1)=106.
  - Cursor (0,2); each write 1 cycle after its accept.
- Set cursor to (14,79) via 14 LFs + 79 chars, then send 'Z': write (14,79)=90. Then 80 blanks on row 15, cursor (15,0).
- From row 29, send LF: cursor (0,0) and row 0 is blanked (80 writes).
- Send CR and 0x01 back-to-back with in_valid held: both accepted on consecutive edges with no write_en.
- BS at col 0: no write.
- BS at (3,5): writes (3,4)=8'h20, cursor (3,4).
- FF mid-screen followed by reset 100 cycles into the sweep: the sweep restarts at (0,0) and completes 2400 writes.
